wb_stage: RTL and testbench

- MEM/WB pipeline register and writeback driver for the 16-bit pipelined CPU.
- Captures the instruction leaving MEM and selects the writeback value from ALU result, load data or PC+2.
- Drives the write port of the register file (DstReg/WriteReg/DstData) and exposes the same values for forwarding.
- Detects HLT retirement and keeps a sticky halted flag plus a retired-instruction counter.

---
 rtl/wb_stage.sv | 109 ++++++++++
 tb/tb_wb_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and register-file writeback driver.
// Tracks HLT retirement (sticky halted) and counts retired instructions.
module wb_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [3:0]        mem_rd,
    input  logic              mem_regwrite,
    input  logic [1:0]        mem_wbsel,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [DATA_W-1:0] mem_pc_plus2,
    input  logic              mem_halt,
    input  logic              stall,
    input  logic              flush,
    output logic [3:0]        DstReg,
    output logic              WriteReg,
    output logic [DATA_W-1:0] DstData,
    output logic              wb_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_count
);

    logic [3:0]        rdQ;
    logic              regWriteQ;
    logic [1:0]        wbSelQ;
    logic [DATA_W-1:0] aluQ;
    logic [DATA_W-1:0] loadQ;
    logic [DATA_W-1:0] pcQ;
    logic              haltQ;
    logic              validQ;
    logic              doneQ;
    logic              haltedQ;
    logic [CNT_W-1:0]  retireQ;

    // First (and only) cycle an instruction is live in WB.
    logic              firstCycle;
    logic              retireNow;

    assign firstCycle = validQ & ~doneQ;
    assign retireNow  = firstCycle & ~haltedQ;

    // Pipeline register: halted freezes, flush bubbles, stall holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdQ       <= '0;
            regWriteQ <= 1'b0;
            wbSelQ    <= '0;
            aluQ      <= '0;
            loadQ     <= '0;
            pcQ       <= '0;
            haltQ     <= 1'b0;
            validQ    <= 1'b0;
            doneQ     <= 1'b0;
        end else if (haltedQ) begin
            validQ    <= validQ;
        end else if (flush) begin
            validQ    <= 1'b0;
            doneQ     <= 1'b0;
        end else if (stall) begin
            doneQ     <= validQ;
        end else begin
            rdQ       <= mem_rd;
            regWriteQ <= mem_regwrite;
            wbSelQ    <= mem_wbsel;
            aluQ      <= mem_alu_result;
            loadQ     <= mem_load_data;
            pcQ       <= mem_pc_plus2;
            haltQ     <= mem_halt;
            validQ    <= mem_valid;
            doneQ     <= 1'b0;
        end
    end

    // Sticky halt and retire counter, evaluated on the cycle just ending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haltedQ <= 1'b0;
            retireQ <= '0;
        end else if (retireNow) begin
            retireQ <= retireQ + 1'b1;
            if (haltQ) begin
                haltedQ <= 1'b1;
            end
        end
    end

    // Writeback value select; the illegal encoding drives zero.
    always_comb begin
        DstData = '0;
        case (wbSelQ)
            2'b00:   DstData = aluQ;
            2'b01:   DstData = loadQ;
            2'b10:   DstData = pcQ;
            default: DstData = '0;
        endcase
    end

    assign DstReg       = rdQ;
    assign WriteReg     = retireNow & regWriteQ
                        & (rdQ != 4'd0) & (wbSelQ != 2'b11);
    assign wb_valid     = validQ;
    assign halted       = haltedQ;
    assign retire_count = retireQ;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [3:0]  mem_rd;
    logic        mem_regwrite;
    logic [1:0]  mem_wbsel;
    logic [15:0] mem_alu_result;
    logic [15:0] mem_load_data;
    logic [15:0] mem_pc_plus2;
    logic        mem_halt;
    logic        stall;
    logic        flush;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic        wb_valid;
    logic        halted;
    logic [15:0] retire_count;

    int total = 0;
    int fails = 0;

    wb_stage dut (
        .clk(clk),
        .rst(rst),
        .mem_valid(mem_valid),
        .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite),
        .mem_wbsel(mem_wbsel),
        .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data),
        .mem_pc_plus2(mem_pc_plus2),
        .mem_halt(mem_halt),
        .stall(stall),
        .flush(flush),
        .DstReg(DstReg),
        .WriteReg(WriteReg),
        .DstData(DstData),
        .wb_valid(wb_valid),
        .halted(halted),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        mem_valid      = 1'b0;
        mem_rd         = 4'd0;
        mem_regwrite   = 1'b0;
        mem_wbsel      = 2'b00;
        mem_alu_result = 16'h0;
        mem_load_data  = 16'h0;
        mem_pc_plus2   = 16'h0;
        mem_halt       = 1'b0;
    endtask

    task automatic instr(input logic [3:0] rd,
                         input logic [1:0] sel,
                         input logic [15:0] val);
        mem_valid      = 1'b1;
        mem_rd         = rd;
        mem_regwrite   = 1'b1;
        mem_wbsel      = sel;
        mem_alu_result = (sel == 2'b00) ? val : 16'hAAAA;
        mem_load_data  = (sel == 2'b01) ? val : 16'h5555;
        mem_pc_plus2   = (sel == 2'b10) ? val : 16'h3333;
        mem_halt       = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        bubble();
        #12;
        check("rst_DstReg", 32'(DstReg), 32'd0);
        check("rst_WriteReg", 32'(WriteReg), 32'd0);
        check("rst_DstData", 32'(DstData), 32'd0);
        check("rst_valid", 32'(wb_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(retire_count), 32'd0);
        step();
        rst = 1'b0;

        // ADD R3
        instr(4'd3, 2'b00, 16'h1234);
        step();
        check("add_DstReg", 32'(DstReg), 32'd3);
        check("add_WriteReg", 32'(WriteReg), 32'd1);
        check("add_DstData", 32'(DstData), 32'h1234);
        check("add_count0", 32'(retire_count), 32'd0);
        bubble();
        step();
        check("add_count1", 32'(retire_count), 32'd1);
        check("bub_WriteReg", 32'(WriteReg), 32'd0);
        check("bub_count", 32'(retire_count), 32'd1);

        // Reset in the middle of a live writeback
        instr(4'd3, 2'b00, 16'h1234);
        step();
        check("pre_rst_WriteReg", 32'(WriteReg), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_WriteReg", 32'(WriteReg), 32'd0);
        check("midrst_count", 32'(retire_count), 32'd0);
        check("midrst_valid", 32'(wb_valid), 32'd0);
        step();
        check("rsthold_WriteReg", 32'(WriteReg), 32'd0);
        rst = 1'b0;
        bubble();
        step();

        // LW R5 then PCS R7
        instr(4'd5, 2'b01, 16'hBEEF);
        step();
        check("lw_DstReg", 32'(DstReg), 32'd5);
        check("lw_WriteReg", 32'(WriteReg), 32'd1);
        check("lw_DstData", 32'(DstData), 32'hBEEF);
        instr(4'd7, 2'b10, 16'h0042);
        step();
        check("pcs_DstReg", 32'(DstReg), 32'd7);
        check("pcs_WriteReg", 32'(WriteReg), 32'd1);
        check("pcs_DstData", 32'(DstData), 32'h0042);
        bubble();
        step();
        check("lwpcs_count", 32'(retire_count), 32'd2);

        // Write to R0 is suppressed but retires
        instr(4'd0, 2'b00, 16'hFFFF);
        step();
        check("r0_WriteReg", 32'(WriteReg), 32'd0);
        check("r0_valid", 32'(wb_valid), 32'd1);
        bubble();
        step();
        check("r0_count", 32'(retire_count), 32'd3);

        // Illegal wbsel
        instr(4'd6, 2'b11, 16'h7777);
        step();
        check("ill_DstData", 32'(DstData), 32'd0);
        check("ill_WriteReg", 32'(WriteReg), 32'd0);
        bubble();
        step();
        check("ill_count", 32'(retire_count), 32'd4);

        // Stall: write once, count once
        instr(4'd4, 2'b00, 16'h0404);
        step();
        check("stl_first_we", 32'(WriteReg), 32'd1);
        instr(4'd9, 2'b00, 16'h9999);
        stall = 1'b1;
        step();
        check("stl1_we", 32'(WriteReg), 32'd0);
        check("stl1_DstReg", 32'(DstReg), 32'd4);
        check("stl1_data", 32'(DstData), 32'h0404);
        check("stl1_valid", 32'(wb_valid), 32'd1);
        step();
        check("stl2_we", 32'(WriteReg), 32'd0);
        step();
        check("stl3_we", 32'(WriteReg), 32'd0);
        stall = 1'b0;
        bubble();
        step();
        check("stl_count", 32'(retire_count), 32'd5);

        // Flush beats stall
        instr(4'd1, 2'b00, 16'h0101);
        step();
        check("fl_pre_we", 32'(WriteReg), 32'd1);
        stall = 1'b1;
        flush = 1'b1;
        step();
        check("fl_valid", 32'(wb_valid), 32'd0);
        check("fl_we", 32'(WriteReg), 32'd0);
        stall = 1'b0;
        flush = 1'b0;
        bubble();
        step();
        check("fl_count", 32'(retire_count), 32'd6);

        // HLT then ADD R2
        bubble();
        mem_valid = 1'b1;
        mem_halt  = 1'b1;
        step();
        check("hlt_wb_halted", 32'(halted), 32'd0);
        instr(4'd2, 2'b00, 16'h2222);
        step();
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_we", 32'(WriteReg), 32'd0);
        check("hlt_count", 32'(retire_count), 32'd7);
        for (int i = 0; i < 10; i++) begin
            mem_valid      = 1'($urandom);
            mem_rd         = 4'($urandom);
            mem_regwrite   = 1'b1;
            mem_wbsel      = 2'($urandom_range(0, 2));
            mem_alu_result = 16'($urandom);
            mem_halt       = 1'($urandom);
            stall          = 1'($urandom);
            flush          = 1'($urandom);
            step();
            check("frz_we", 32'(WriteReg), 32'd0);
            check("frz_halted", 32'(halted), 32'd1);
            check("frz_count", 32'(retire_count), 32'd7);
            check("frz_DstReg", 32'(DstReg), 32'd2);
        end
        stall = 1'b0;
        flush = 1'b0;

        // Counter wrap
        rst = 1'b1;
        bubble();
        #2;
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_count", 32'(retire_count), 32'd0);
        step();
        rst = 1'b0;
        instr(4'd1, 2'b00, 16'h0001);
        for (int i = 0; i < 65536; i++) step();
        check("wrap_max", 32'(retire_count), 32'hFFFF);
        step();
        check("wrap_zero", 32'(retire_count), 32'h0000);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
